escalonador_programas: RTL and testbench
========================================

# escalonador_programas

Round-robin program scheduler for the multiprogram processor. It keeps NPROG program slots, each with an active bit and a saved resume PC. It reacts to the control unit's `nextProgram` (yield) and `endProgram` (halt) strobes and to an optional time quantum, and sequences each context switch. During a switch it freezes the datapath, selects the next active slot and drives a one-cycle PC load with that slot's saved PC.

## Interface
- `NPROG`, 4: number of program slots (power of two, ≥2); `W = log2(NPROG)`.
- `QUANTUM`, 256: EXECUTA cycles before preemption (≥2).
- `LARG_PC`, 32: PC width.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `nextProgram`  in  1  yield strobe from control unit.
- `endProgram`  in  1  halt strobe from control unit.
- `pc_retorno`  in  LARG_PC  resume address of current program; sampled on the accepted-event cycle.
- `preempcao_hab`  in  1  enables quantum preemption.
- `criar`  in  1  activate slot `criar_slot` with start PC `criar_pc`.
- `criar_slot`  in  W  slot to activate.
- `criar_pc`  in  LARG_PC  start PC for the new slot.
- `parar`  out  1  freeze PC/register writes; high in every state except EXECUTA.
- `carrega_pc`  out  1  one-cycle pulse; datapath loads `pc_novo`.
- `pc_novo`  out  LARG_PC  PC to load (registered).
- `programa_atual`  out  W  slot currently owning the processor.
- `ocioso`  out  1  high in OCIOSO (no active program).

## Operation
- State: `estado`; `ativo[NPROG]`; `pc_salvo[NPROG]`; `atual` (W bits); `contador` (quantum, log2(QUANTUM) bits).
- FSM states are OCIOSO, EXECUTA, BUSCA and CARREGA.
- OCIOSO:
  - Go to BUSCA when the registered `ativo` vector is nonzero.
- EXECUTA event priority: endProgram > nextProgram > quantum expiry.
  - `endProgram`: clear `ativo[atual]`; PC not saved. Next state BUSCA.
  - `nextProgram`, or `preempcao_hab && contador==QUANTUM-1`: `pc_salvo[atual] <= pc_retorno`. Next state BUSCA.
  - Otherwise: `contador` increments.
- BUSCA:
  - Search order is `atual+1, atual+2, …, atual`, modulo NPROG (the current slot is checked last). Take the first slot with `ativo` set.
  - If a slot is found: `atual <= sel`, `pc_novo <= pc_salvo[sel]`, next state CARREGA.
  - If none is found: next state OCIOSO.
- CARREGA:
  - `carrega_pc = 1`; `contador <= 0`; next state EXECUTA.
- `criar` is honoured in any state, but only if `ativo[criar_slot]` is 0 at that cycle. It sets `ativo[criar_slot]` and `pc_salvo[criar_slot] <= criar_pc`. `criar` targeting an active slot is ignored.
- Same-cycle `endProgram` and `criar` on slot `atual`: `criar` is ignored, because the slot is active at that cycle. The slot ends up cleared.
- `nextProgram`/`endProgram` outside EXECUTA are ignored.
- A lone active program that yields reloads its own saved PC.
- `contador` is held outside EXECUTA. With `preempcao_hab=0` it saturates at QUANTUM-1.

## Timing
- Reset values:
  - Outputs: `parar=1`, `carrega_pc=0`, `pc_novo=0`, `programa_atual=0`, `ocioso=1`.
  - Internal state: estado=OCIOSO, `ativo=0`, all `pc_salvo=0`, `contador=0`.
- `parar`, `ocioso` and `carrega_pc` decode combinationally from `estado`. `pc_novo` and `programa_atual` are registered.
- Switch latency, for an event accepted in EXECUTA cycle N:
  - N+1: BUSCA.
  - N+2: CARREGA, `carrega_pc=1`.
  - N+3: EXECUTA, `parar=0`.
- Start from idle, with `criar` in cycle N: ativo set at the end of N; N+1 OCIOSO; N+2 BUSCA; N+3 CARREGA; N+4 EXECUTA.
- Preemption fires in the QUANTUM-th EXECUTA cycle after CARREGA.
- Reset asserted mid-switch forces all reset values asynchronously. No partial save survives.

## Test plan
- Reset → `parar=1`, `ocioso=1`, `carrega_pc=0`, `pc_novo=0`, `programa_atual=0`. Events before any `criar` keep the block in OCIOSO.
- `criar` slot 2, PC 0x100, at cycle N from OCIOSO → `carrega_pc=1`, `pc_novo=0x100`, `programa_atual=2` at N+3; `parar=0`, `ocioso=0` at N+4.
- Slots 0 (0x000) and 2 (0x200) active, running 0; `nextProgram` with `pc_retorno=0x24` → slot 2 loaded with 0x200. A later `nextProgram` → slot 0 loaded with 0x24.
- QUANTUM=8, two active slots, `preempcao_hab=1` → switch accepted on the 8th EXECUTA cycle. Same setup with `preempcao_hab=0` over 50 cycles → no `carrega_pc`.
- Single active slot; `endProgram` together with `nextProgram` → `ativo` cleared, `pc_salvo` unchanged, BUSCA→OCIOSO, `ocioso=1`. A repeated `criar` to an active slot leaves its `pc_salvo` unchanged.
- `reset` pulsed during CARREGA → `carrega_pc` drops the same cycle. After release: OCIOSO, `ativo=0`, `pc_novo=0`.

Source files
------------

// File: rtl/escalonador_programas.sv
// Round-robin scheduler for the multiprogram processor: tracks active program slots and
// their resume PCs, and sequences each context switch (save, search, PC load).
module escalonador_programas #(
    parameter int NPROG   = 4,
    parameter int QUANTUM = 256,
    parameter int LARG_PC = 32,
    localparam int W      = $clog2(NPROG),
    localparam int CW     = $clog2(QUANTUM)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               nextProgram,
    input  logic               endProgram,
    input  logic [LARG_PC-1:0] pc_retorno,
    input  logic               preempcao_hab,
    input  logic               criar,
    input  logic [W-1:0]       criar_slot,
    input  logic [LARG_PC-1:0] criar_pc,
    output logic               parar,
    output logic               carrega_pc,
    output logic [LARG_PC-1:0] pc_novo,
    output logic [W-1:0]       programa_atual,
    output logic               ocioso
);

    typedef enum logic [1:0] {OCIOSO, EXECUTA, BUSCA, CARREGA} estado_t;

    estado_t            estado;
    logic [NPROG-1:0]   ativo;
    logic [LARG_PC-1:0] pc_salvo [NPROG];
    logic [W-1:0]       atual;
    logic [CW-1:0]      contador;

    logic [W-1:0]       sel;
    logic [W-1:0]       idx;
    logic               achou;
    logic               expira;

    // Walk downward so the nearest slot after atual wins; k == NPROG wraps to atual itself.
    always_comb begin
        sel   = atual;
        idx   = atual;
        achou = 1'b0;
        for (int k = NPROG; k >= 1; k--) begin
            idx = atual + W'(k);
            if (ativo[idx]) begin
                sel   = idx;
                achou = 1'b1;
            end
        end
    end

    assign expira         = preempcao_hab && (contador == CW'(QUANTUM - 1));
    assign parar          = (estado != EXECUTA);
    assign ocioso         = (estado == OCIOSO);
    assign carrega_pc     = (estado == CARREGA);
    assign programa_atual = atual;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= OCIOSO;
            ativo    <= '0;
            atual    <= '0;
            contador <= '0;
            pc_novo  <= '0;
            for (int i = 0; i < NPROG; i++) begin
                pc_salvo[i] <= '0;
            end
        end else begin
            case (estado)
                OCIOSO: begin
                    if (|ativo) begin
                        estado <= BUSCA;
                    end
                end
                EXECUTA: begin
                    if (endProgram) begin
                        ativo[atual] <= 1'b0;
                        estado       <= BUSCA;
                    end else if (nextProgram || expira) begin
                        pc_salvo[atual] <= pc_retorno;
                        estado          <= BUSCA;
                    end else if (contador != CW'(QUANTUM - 1)) begin
                        contador <= contador + 1'b1;
                    end
                end
                BUSCA: begin
                    if (achou) begin
                        atual   <= sel;
                        pc_novo <= pc_salvo[sel];
                        estado  <= CARREGA;
                    end else begin
                        estado <= OCIOSO;
                    end
                end
                CARREGA: begin
                    contador <= '0;
                    estado   <= EXECUTA;
                end
                default: estado <= OCIOSO;
            endcase

            // The running slot is always active, so creation never collides with its save/clear.
            if (criar && !ativo[criar_slot]) begin
                ativo[criar_slot]    <= 1'b1;
                pc_salvo[criar_slot] <= criar_pc;
            end
        end
    end

endmodule

// File: tb/tb_escalonador_programas.sv
// Scoreboard bench for escalonador_programas: expected PC loads are queued when a switch
// is provoked and compared whenever the scheduler pulses carrega_pc.
module tb_escalonador_programas;

    localparam int NPROG   = 4;
    localparam int QUANTUM = 8;
    localparam int LARG_PC = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        nextProgram = 1'b0;
    logic        endProgram = 1'b0;
    logic [31:0] pc_retorno = '0;
    logic        preempcao_hab = 1'b0;
    logic        criar = 1'b0;
    logic [1:0]  criar_slot = '0;
    logic [31:0] criar_pc = '0;
    logic        parar;
    logic        carrega_pc;
    logic [31:0] pc_novo;
    logic [1:0]  programa_atual;
    logic        ocioso;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0]  slot;
        logic [31:0] pc;
    } carga_t;

    carga_t sb[$];

    escalonador_programas #(.NPROG(NPROG), .QUANTUM(QUANTUM), .LARG_PC(LARG_PC)) dut (
        .clock(clock), .reset(reset), .nextProgram(nextProgram), .endProgram(endProgram),
        .pc_retorno(pc_retorno), .preempcao_hab(preempcao_hab), .criar(criar),
        .criar_slot(criar_slot), .criar_pc(criar_pc), .parar(parar), .carrega_pc(carrega_pc),
        .pc_novo(pc_novo), .programa_atual(programa_atual), .ocioso(ocioso)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        carga_t e;
        if (!reset && carrega_pc) begin
            check_val("load_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("load_slot", 64'(programa_atual), 64'(e.slot));
                check_val("load_pc", 64'(pc_novo), 64'(e.pc));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic criar_em(input logic [1:0] s, input logic [31:0] pc);
        criar      = 1'b1;
        criar_slot = s;
        criar_pc   = pc;
        step();
        criar = 1'b0;
    endtask

    task automatic wait_load(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            seen = carrega_pc;
        end
        check_val(tag, 64'(seen), 64'd1);
        step();
        check_val({tag, "_run"}, 64'(parar), 64'd0);
    endtask

    task automatic yield(input logic [31:0] pc_ret, input logic [1:0] exp_slot,
                         input logic [31:0] exp_pc);
        sb.push_back({exp_slot, exp_pc});
        nextProgram = 1'b1;
        pc_retorno  = pc_ret;
        step();
        nextProgram = 1'b0;
        check_val("yield_busca_parar", 64'(parar), 64'd1);
        check_val("yield_busca_load", 64'(carrega_pc), 64'd0);
        step();
        check_val("yield_carrega", 64'(carrega_pc), 64'd1);
        step();
        check_val("yield_executa", 64'(parar), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int loads;
        #12;
        check_val("rst_parar", 64'(parar), 64'd1);
        check_val("rst_carrega", 64'(carrega_pc), 64'd0);
        check_val("rst_pc_novo", 64'(pc_novo), 64'd0);
        check_val("rst_prog", 64'(programa_atual), 64'd0);
        check_val("rst_ocioso", 64'(ocioso), 64'd1);
        step();
        reset = 1'b0;

        nextProgram = 1'b1;
        endProgram  = 1'b1;
        repeat (3) step();
        nextProgram = 1'b0;
        endProgram  = 1'b0;
        check_val("idle_events_ocioso", 64'(ocioso), 64'd1);
        check_val("idle_events_parar", 64'(parar), 64'd1);

        // Start from idle: criar at N, load visible at N+3, running at N+4.
        sb.push_back({2'd2, 32'h100});
        criar_em(2'd2, 32'h100);
        check_val("start_n1_ocioso", 64'(ocioso), 64'd1);
        step();
        check_val("start_n2_ocioso", 64'(ocioso), 64'd0);
        check_val("start_n2_carrega", 64'(carrega_pc), 64'd0);
        step();
        check_val("start_n3_carrega", 64'(carrega_pc), 64'd1);
        check_val("start_n3_pc", 64'(pc_novo), 64'h100);
        check_val("start_n3_prog", 64'(programa_atual), 64'd2);
        step();
        check_val("start_n4_parar", 64'(parar), 64'd0);
        check_val("start_n4_ocioso", 64'(ocioso), 64'd0);

        // Lone program ends while also yielding and being re-created.
        endProgram  = 1'b1;
        nextProgram = 1'b1;
        pc_retorno  = 32'hDEAD;
        criar       = 1'b1;
        criar_slot  = 2'd2;
        criar_pc    = 32'h555;
        step();
        endProgram  = 1'b0;
        nextProgram = 1'b0;
        criar       = 1'b0;
        check_val("end_ativo", 64'(dut.ativo), 64'd0);
        check_val("end_pc_salvo", 64'(dut.pc_salvo[2]), 64'h100);
        check_val("end_busca_ocioso", 64'(ocioso), 64'd0);
        step();
        check_val("end_ocioso", 64'(ocioso), 64'd1);
        step();
        check_val("end_stays_ocioso", 64'(ocioso), 64'd1);

        // Two programs, round-robin yields.
        sb.push_back({2'd0, 32'h0});
        criar_em(2'd0, 32'h0);
        criar_em(2'd2, 32'h200);
        wait_load("two_start");
        yield(32'h24, 2'd2, 32'h200);
        yield(32'h208, 2'd0, 32'h24);
        criar_em(2'd2, 32'h999);
        check_val("recriar_ignored", 64'(dut.pc_salvo[2]), 64'h208);
        yield(32'h30, 2'd2, 32'h208);

        // Quantum preemption on the QUANTUM-th EXECUTA cycle.
        sb.push_back({2'd0, 32'h30});
        preempcao_hab = 1'b1;
        pc_retorno    = 32'h40;
        repeat (QUANTUM - 1) step();
        check_val("preempt_e8_running", 64'(parar), 64'd0);
        step();
        check_val("preempt_busca_parar", 64'(parar), 64'd1);
        check_val("preempt_busca_load", 64'(carrega_pc), 64'd0);
        step();
        check_val("preempt_carrega", 64'(carrega_pc), 64'd1);
        step();
        preempcao_hab = 1'b0;
        loads = 0;
        repeat (50) begin
            step();
            if (carrega_pc) loads++;
        end
        check_val("no_preempt_loads", 64'(loads), 64'd0);
        check_val("no_preempt_running", 64'(parar), 64'd0);
        check_val("sb_drained", 64'(sb.size()), 64'd0);

        // Reset in the middle of a switch.
        sb.push_back({2'd2, 32'h40});
        nextProgram = 1'b1;
        pc_retorno  = 32'h50;
        step();
        nextProgram = 1'b0;
        step();
        check_val("rst_mid_carrega_before", 64'(carrega_pc), 64'd1);
        #1 reset = 1'b1;
        #1;
        check_val("rst_mid_carrega_drop", 64'(carrega_pc), 64'd0);
        check_val("rst_mid_parar", 64'(parar), 64'd1);
        check_val("rst_mid_pc_novo", 64'(pc_novo), 64'd0);
        sb.delete();
        step();
        reset = 1'b0;
        step();
        check_val("post_rst_ocioso", 64'(ocioso), 64'd1);
        check_val("post_rst_ativo", 64'(dut.ativo), 64'd0);
        check_val("post_rst_pc_novo", 64'(pc_novo), 64'd0);
        check_val("post_rst_prog", 64'(programa_atual), 64'd0);
        check_val("post_rst_pc_salvo", 64'(dut.pc_salvo[0]), 64'd0);
        step();
        check_val("post_rst_stays_ocioso", 64'(ocioso), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
